pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 3, register-index width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles (1..3).
REQ-003 SHALL have parameter CNT_W, default 16, perf counter width.
REQ-004 SHALL have ports: CLK in 1, rising-edge clock; RST in 1, synchronous active-high reset.
REQ-005 SHALL have ports: id_rs1, id_rs2 in REG_AW, ID source regs; id_use1, id_use2 in 1, source valid flags.
REQ-006 SHALL have ports: ex_rd in REG_AW; ex_we in 1; ex_load in 1, EX holds a load.
REQ-007 SHALL have ports: mem_rd in REG_AW, mem_we in 1; wb_rd in REG_AW, wb_we in 1.
REQ-008 SHALL have ports: id_redirect in 1, taken branch/jump resolved in ID; mem_busy in 1, data memory not ready.
REQ-009 SHALL have outputs: hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb, flush_ifid, bubble_idex, each 1.
REQ-010 SHALL have outputs: fwd_a, fwd_b 2 bits each (0 reg file, 1 EX/MEM, 2 MEM/WB); busy 1, FSM not in RUN.

Function
REQ-011 SHALL implement FSM states RUN, LU_STALL, FREEZE.
REQ-012 Load-use hazard = ex_load & ex_we & ex_rd!=0 & ((id_use1 & id_rs1==ex_rd) | (id_use2 & id_rs2==ex_rd)).
REQ-013 Priority, highest first: mem_busy, load-use, id_redirect.
REQ-014 mem_busy=1 (any state): all hold_* =1, flush/bubble =0; state FREEZE; stall counter preserved.
REQ-015 FREEZE -> on mem_busy=0 return to state held before freeze; outputs reevaluated same cycle.
REQ-016 RUN + load-use: hold_pc=hold_ifid=1, bubble_idex=1, same cycle (combinational); if LOAD_LAT>1 enter LU_STALL with counter=LOAD_LAT-1.
REQ-017 LU_STALL: same outputs as REQ-016; counter decrements per cycle; exits to RUN after count reaches 0.
REQ-018 Load-use and id_redirect same cycle: redirect ignored, flush_ifid=0; ID held, so redirect is re-presented later.
REQ-019 RUN + id_redirect, no hazard: flush_ifid=1 for exactly that cycle, no holds.
REQ-020 fwd_a: 1 if mem_we & mem_rd==id_rs1 & mem_rd!=0; else 2 if wb_we & wb_rd==id_rs1 & wb_rd!=0; else 0. fwd_b same with id_rs2.
REQ-021 Register index 0 SHALL never forward or cause a hazard.
REQ-022 fwd_* purely combinational, valid in every state incl. FREEZE.
REQ-023 busy=1 in LU_STALL and FREEZE, 0 in RUN.

Reset
REQ-024 RST=1 at rising CLK: state RUN, counters 0; all hold/flush/bubble outputs 0 while RST=1.
REQ-025 RST mid-stall or mid-freeze SHALL abort to RUN next cycle with no residual hold.

Configuration
REQ-026 Macro HAZ_PERF_CNT_EN defined: outputs stall_cnt, flush_cnt (CNT_W) count cycles with bubble_idex=1 and flush_ifid=1; saturate at all-ones; cleared by RST.
REQ-027 Macro undefined: those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-028 Shared package pipe_pkg SHALL hold FSM state typedef, fwd select constants (FWD_RF, FWD_EXMEM, FWD_MEMWB) and REG_AW default.
REQ-029 Forwarding comparison SHALL be sub-module fwd_sel, instantiated twice (A, B).

Verification
REQ-030 RST then ex_load=1, ex_we=1, ex_rd=3, id_rs1=3, id_use1=1 -> hold_pc=hold_ifid=bubble_idex=1 for 1 cycle (LOAD_LAT=1), then RUN.
REQ-031 LOAD_LAT=3, same hazard -> bubble_idex=1 for 3 consecutive cycles, busy=1 for last 2.
REQ-032 id_redirect=1 plus load-use same cycle -> flush_ifid=0, bubble_idex=1; redirect next cycle -> flush_ifid=1.
REQ-033 mem_rd=wb_rd=5, both we=1, id_rs2=5 -> fwd_b=1; mem_we=0 -> fwd_b=2; id_rs2=0 -> fwd_b=0.
REQ-034 mem_busy=1 during LU_STALL for 4 cycles -> all hold_* =1, counter frozen; release -> stall resumes remaining cycles.
REQ-035 HAZ_PERF_CNT_EN, CNT_W=4, 20 load-use stalls -> stall_cnt=15 saturated; RST -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state type,
// forwarding select codes, default register-index width and the load-use
// stall counter helpers.
package pipe_pkg;

    // Default register-index width (8 architectural registers).
    localparam int REG_AW_DEFAULT = 3;

    // Operand source selects presented to the EX-stage operand muxes.
    localparam logic [1:0] FWD_RF    = 2'd0;   // register file value
    localparam logic [1:0] FWD_EXMEM = 2'd1;   // EX/MEM pipeline register
    localparam logic [1:0] FWD_MEMWB = 2'd2;   // MEM/WB pipeline register

    // Width of the remaining-stall counter. It is wide enough for LOAD_LAT up to 3.
    localparam int LU_CNT_W = 2;

    // Controller states. FREEZE remembers which of the other two it interrupted.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FREEZE   = 2'd2
    } haz_state_t;

    // Number of extra LU_STALL cycles after the first, combinational bubble.
    function automatic logic [LU_CNT_W-1:0] lu_stall_init(input int load_lat);
        return LU_CNT_W'(load_lat - 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one ID-stage source operand. The youngest producer
// (EX/MEM) wins over MEM/WB. Register 0 is hard-wired and never forwarded.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    output logic [1:0]        sel
);

    // Priority compare: EX/MEM result first, then MEM/WB, else register file
    always_comb begin
        sel = FWD_RF;
        if (mem_we && (mem_rd == rs) && (mem_rd != '0)) begin
            sel = FWD_EXMEM;
        end else if (wb_we && (wb_rd == rs) && (wb_rd != '0)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, ID-stage redirect flush,
// data-memory freeze and operand forwarding selects.
// Optional macro HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters
// (stall_cnt, flush_cnt). Without the macro those ports do not exist.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEFAULT,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic              id_redirect,
    input  logic              mem_busy,
    output logic              hold_pc,
    output logic              hold_ifid,
    output logic              hold_idex,
    output logic              hold_exmem,
    output logic              hold_memwb,
    output logic              flush_ifid,
    output logic              bubble_idex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam logic [LU_CNT_W-1:0] LU_INIT = lu_stall_init(LOAD_LAT);
    localparam logic [LU_CNT_W-1:0] LU_ONE  = LU_CNT_W'(1);

    haz_state_t          state_reg, state_next;
    haz_state_t          saved_reg, saved_next;   // state interrupted by FREEZE
    haz_state_t          eff_state;               // state whose rules apply this cycle
    logic [LU_CNT_W-1:0] cnt_reg, cnt_next;       // LU_STALL cycles still to go
    logic                load_use;

    // ------------------------------------------------------------------
    // Forwarding: one comparator per source operand
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] rs_vec  [2];
    logic [1:0]        sel_vec [2];

    assign rs_vec[0] = id_rs1;
    assign rs_vec[1] = id_rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel #(
                .REG_AW (REG_AW)
            ) u_fwd_sel (
                .rs     (rs_vec[gi]),
                .mem_rd (mem_rd),
                .mem_we (mem_we),
                .wb_rd  (wb_rd),
                .wb_we  (wb_we),
                .sel    (sel_vec[gi])
            );
        end
    endgenerate

    assign fwd_a = sel_vec[0];
    assign fwd_b = sel_vec[1];

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // A load in EX whose destination an ID operand actually reads
    assign load_use = ex_load && ex_we && (ex_rd != '0) &&
                      ((id_use1 && (id_rs1 == ex_rd)) ||
                       (id_use2 && (id_rs2 == ex_rd)));

    // When a freeze lifts, the interrupted state applies in the same cycle
    assign eff_state = (state_reg == ST_FREEZE) ? saved_reg : state_reg;

    // State register with synchronous reset back to RUN
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_RUN;
            saved_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            saved_reg <= saved_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: freeze beats everything and keeps the stall count intact
    always_comb begin
        state_next = state_reg;
        saved_next = saved_reg;
        cnt_next   = cnt_reg;
        if (mem_busy) begin
            state_next = ST_FREEZE;
            saved_next = eff_state;
        end else begin
            saved_next = ST_RUN;
            case (eff_state)
                ST_LU_STALL: begin
                    if (cnt_reg <= LU_ONE) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_LU_STALL;
                        cnt_next   = cnt_reg - LU_ONE;
                    end
                end
                default: begin
                    // The first bubble is combinational, so only longer
                    // load latencies need the LU_STALL state.
                    if (load_use && (LOAD_LAT > 1)) begin
                        state_next = ST_LU_STALL;
                        cnt_next   = LU_INIT;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            endcase
        end
    end

    // Output decode: reset silences all controls, then freeze > load-use > redirect
    always_comb begin
        hold_pc     = 1'b0;
        hold_ifid   = 1'b0;
        hold_idex   = 1'b0;
        hold_exmem  = 1'b0;
        hold_memwb  = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        busy        = (state_reg != ST_RUN);
        if (!RST) begin
            if (mem_busy) begin
                hold_pc    = 1'b1;
                hold_ifid  = 1'b1;
                hold_idex  = 1'b1;
                hold_exmem = 1'b1;
                hold_memwb = 1'b1;
            end else if ((eff_state == ST_LU_STALL) || load_use) begin
                // ID is held, so a concurrent redirect returns once the stall clears
                hold_pc     = 1'b1;
                hold_ifid   = 1'b1;
                bubble_idex = 1'b1;
            end else if (id_redirect) begin
                flush_ifid = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    // Saturating counts of bubble and flush cycles
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (bubble_idex && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (flush_ifid && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    // Counters are not built; CNT_W only sizes this constant tie-off.
    logic [CNT_W-1:0] unused_perf_w;
    assign unused_perf_w = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_LAT=1 and 3) share the
// stimulus. A reference model that tracks remaining stall cycles and the
// freeze condition predicts every output.
module tb_pipe_hazard_ctrl;

    localparam int AW = 3;

    logic CLK = 1'b0;
    logic RST;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use1, id_use2, ex_we, ex_load, mem_we, wb_we, id_redirect, mem_busy;

    logic [1:0] hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb;
    logic [1:0] flush_ifid, bubble_idex, busy;
    logic [1:0] fwd_a [2];
    logic [1:0] fwd_b [2];
`ifdef HAZ_PERF_CNT_EN
    logic [3:0] stall_cnt [2];
    logic [3:0] flush_cnt [2];
`endif

    always #5 CLK = ~CLK;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            pipe_hazard_ctrl #(
                .REG_AW   (AW),
                .LOAD_LAT ((gi == 0) ? 1 : 3),
                .CNT_W    (4)
            ) u_dut (
                .CLK         (CLK),
                .RST         (RST),
                .id_rs1      (id_rs1),
                .id_rs2      (id_rs2),
                .id_use1     (id_use1),
                .id_use2     (id_use2),
                .ex_rd       (ex_rd),
                .ex_we       (ex_we),
                .ex_load     (ex_load),
                .mem_rd      (mem_rd),
                .mem_we      (mem_we),
                .wb_rd       (wb_rd),
                .wb_we       (wb_we),
                .id_redirect (id_redirect),
                .mem_busy    (mem_busy),
                .hold_pc     (hold_pc[gi]),
                .hold_ifid   (hold_ifid[gi]),
                .hold_idex   (hold_idex[gi]),
                .hold_exmem  (hold_exmem[gi]),
                .hold_memwb  (hold_memwb[gi]),
                .flush_ifid  (flush_ifid[gi]),
                .bubble_idex (bubble_idex[gi]),
                .fwd_a       (fwd_a[gi]),
                .fwd_b       (fwd_b[gi]),
                .busy        (busy[gi])
`ifdef HAZ_PERF_CNT_EN
                ,
                .stall_cnt   (stall_cnt[gi]),
                .flush_cnt   (flush_cnt[gi])
`endif
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per instance
    int lat        [2] = '{1, 3};
    int stall_left [2];      // LU_STALL cycles still owed after this one
    bit frozen     [2];      // previous cycle was frozen
    bit exp_bubble [2];
    bit exp_flush  [2];
    int exp_scnt   [2];
    int exp_fcnt   [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hazard();
        return ex_load && ex_we && (ex_rd != 0) &&
               ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));
    endfunction

    function automatic int fwd_model(input logic [AW-1:0] rs);
        if (mem_we && mem_rd == rs && mem_rd != 0) return 1;
        if (wb_we && wb_rd == rs && wb_rd != 0) return 2;
        return 0;
    endfunction

    // Compare all outputs of both instances against the model for this cycle
    task automatic eval_and_check(input string tag);
        for (int i = 0; i < 2; i++) begin
            logic [4:0] e_hold;
            bit e_bb, e_fl;
            e_hold = 5'b0; e_bb = 0; e_fl = 0;
            if (!RST) begin
                if (mem_busy) e_hold = 5'b11111;
                else if (stall_left[i] > 0 || hazard()) begin
                    e_hold = 5'b11000; e_bb = 1;
                end else if (id_redirect) e_fl = 1;
            end
            exp_bubble[i] = e_bb;
            exp_flush[i]  = e_fl;
            check_eq($sformatf("%s L%0d hold", tag, lat[i]),
                     {27'd0, hold_pc[i], hold_ifid[i], hold_idex[i], hold_exmem[i], hold_memwb[i]},
                     {27'd0, e_hold});
            check_eq($sformatf("%s L%0d flush", tag, lat[i]), 32'(flush_ifid[i]), 32'(e_fl));
            check_eq($sformatf("%s L%0d bubble", tag, lat[i]), 32'(bubble_idex[i]), 32'(e_bb));
            check_eq($sformatf("%s L%0d busy", tag, lat[i]), 32'(busy[i]),
                     32'(frozen[i] || stall_left[i] > 0));
            check_eq($sformatf("%s L%0d fwd_a", tag, lat[i]), 32'(fwd_a[i]), 32'(fwd_model(id_rs1)));
            check_eq($sformatf("%s L%0d fwd_b", tag, lat[i]), 32'(fwd_b[i]), 32'(fwd_model(id_rs2)));
`ifdef HAZ_PERF_CNT_EN
            check_eq($sformatf("%s L%0d stall_cnt", tag, lat[i]), 32'(stall_cnt[i]), 32'(exp_scnt[i]));
            check_eq($sformatf("%s L%0d flush_cnt", tag, lat[i]), 32'(flush_cnt[i]), 32'(exp_fcnt[i]));
`endif
        end
    endtask

    // Advance the model by one clock edge using the inputs just applied
    task automatic model_update();
        bit hz;
        hz = hazard();
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                stall_left[i] = 0; frozen[i] = 0; exp_scnt[i] = 0; exp_fcnt[i] = 0;
            end else begin
                if (exp_bubble[i] && exp_scnt[i] < 15) exp_scnt[i]++;
                if (exp_flush[i] && exp_fcnt[i] < 15) exp_fcnt[i]++;
                if (mem_busy) frozen[i] = 1;
                else begin
                    frozen[i] = 0;
                    if (stall_left[i] > 0) stall_left[i]--;
                    else if (hz) stall_left[i] = lat[i] - 1;
                end
            end
        end
    endtask

    // One cycle: inputs already set after a falling edge
    task automatic cycle(input string tag);
        #1;
        eval_and_check(tag);
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        RST = 0; id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
        ex_rd = 0; ex_we = 0; ex_load = 0; mem_rd = 0; mem_we = 0;
        wb_rd = 0; wb_we = 0; id_redirect = 0; mem_busy = 0;
    endtask

    task automatic set_load_use();
        ex_load = 1; ex_we = 1; ex_rd = 3; id_rs1 = 3; id_use1 = 1;
    endtask

    task automatic clear_load();
        ex_load = 0; ex_we = 0; ex_rd = 0;
    endtask

    initial begin
        idle_inputs();
        RST = 1;
        for (int i = 0; i < 2; i++) begin
            stall_left[i] = 0; frozen[i] = 0; exp_scnt[i] = 0; exp_fcnt[i] = 0;
        end
        @(posedge CLK);
        @(negedge CLK);
        // Reset held with a hazard present: outputs stay quiet
        set_load_use(); mem_busy = 1;
        #1 check_eq("rst_quiet_hold_pc", 32'(hold_pc[0]), 32'd0);
        cycle("reset");
        idle_inputs();
        cycle("idle");

        // Single load-use: one bubble at LOAD_LAT=1, three at LOAD_LAT=3
        set_load_use();
        #1 check_eq("lu_first_bubble_L1", 32'(bubble_idex[0]), 32'd1);
        cycle("lu1");
        clear_load();
        #1 check_eq("lu_c2_bubble_L1", 32'(bubble_idex[0]), 32'd0);
        check_eq("lu_c2_bubble_L3", 32'(bubble_idex[1]), 32'd1);
        check_eq("lu_c2_busy_L3", 32'(busy[1]), 32'd1);
        cycle("lu2");
        #1 check_eq("lu_c3_bubble_L3", 32'(bubble_idex[1]), 32'd1);
        cycle("lu3");
        #1 check_eq("lu_c4_bubble_L3", 32'(bubble_idex[1]), 32'd0);
        check_eq("lu_c4_busy_L3", 32'(busy[1]), 32'd0);
        cycle("lu4");

        // Redirect together with load-use is ignored, then honoured
        set_load_use(); id_redirect = 1;
        #1 check_eq("redir_lu_flush", 32'(flush_ifid[0]), 32'd0);
        cycle("redir_lu");
        clear_load();
        #1 check_eq("redir_next_flush_L1", 32'(flush_ifid[0]), 32'd1);
        cycle("redir_next");
        id_redirect = 0;
        repeat (3) cycle("settle");

        // Forwarding priority and register-0 exclusion
        mem_rd = 5; wb_rd = 5; mem_we = 1; wb_we = 1; id_rs2 = 5;
        #1 check_eq("fwd_b_exmem", 32'(fwd_b[0]), 32'd1);
        cycle("fwd1");
        mem_we = 0;
        #1 check_eq("fwd_b_memwb", 32'(fwd_b[0]), 32'd2);
        cycle("fwd2");
        id_rs2 = 0; mem_rd = 0; wb_rd = 0; mem_we = 1; wb_we = 1;
        #1 check_eq("fwd_b_r0", 32'(fwd_b[0]), 32'd0);
        cycle("fwd3");
        idle_inputs();

        // Freeze in the middle of a LOAD_LAT=3 stall, then resume
        set_load_use();
        cycle("frz_lu");
        clear_load(); mem_busy = 1;
        repeat (4) begin
            #1 check_eq("frz_hold_memwb", 32'(hold_memwb[1]), 32'd1);
            cycle("frz");
        end
        mem_busy = 0;
        #1 check_eq("frz_resume_bubble_L3", 32'(bubble_idex[1]), 32'd1);
        cycle("frz_rel1");
        cycle("frz_rel2");
        #1 check_eq("frz_done_bubble_L3", 32'(bubble_idex[1]), 32'd0);
        cycle("frz_done");

        // Reset during a stall aborts it
        set_load_use();
        cycle("rst_lu");
        clear_load(); RST = 1;
        cycle("rst_mid");
        RST = 0;
        #1 check_eq("rst_abort_busy_L3", 32'(busy[1]), 32'd0);
        cycle("rst_after");

        // Repeated load-use stalls (saturate perf counters when built)
        repeat (20) begin
            set_load_use();
            cycle("sat_lu");
            clear_load();
            repeat (2) cycle("sat_gap");
        end
        RST = 1;
        cycle("sat_rst");
        RST = 0;
        cycle("sat_post");

        // Randomized traffic over a small register space
        for (int n = 0; n < 3000; n++) begin
            RST         = ($urandom_range(0, 99) == 0);
            id_rs1      = AW'($urandom_range(0, 7));
            id_rs2      = AW'($urandom_range(0, 7));
            id_use1     = 1'($urandom);
            id_use2     = 1'($urandom);
            ex_rd       = AW'($urandom_range(0, 7));
            ex_we       = ($urandom_range(0, 3) != 0);
            ex_load     = ($urandom_range(0, 2) == 0);
            mem_rd      = AW'($urandom_range(0, 7));
            mem_we      = 1'($urandom);
            wb_rd       = AW'($urandom_range(0, 7));
            wb_we       = 1'($urandom);
            id_redirect = ($urandom_range(0, 3) == 0);
            mem_busy    = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
